// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and constants for the operand fetch stage.
// Provides the PC register index, control width and forwarding-source enum.
package arm_core_pkg;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         CTRL_WIDTH = 16;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_PC
    } fwd_src_e;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side and execute-side valid/ready channels of the operand fetch stage.
// master: drives decoded instruction, consumes the slot; slave: the stage itself.
interface operand_fetch_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH = 16
);
    logic                  id_valid;
    logic                  id_ready;
    logic [ADDR_WIDTH-1:0] id_rn;
    logic [ADDR_WIDTH-1:0] id_rm;
    logic [ADDR_WIDTH-1:0] id_rs;
    logic                  id_use_rn;
    logic                  id_use_rm;
    logic                  id_use_rs;
    logic [ADDR_WIDTH-1:0] id_rd;
    logic                  id_rd_we;
    logic                  id_is_load;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [CTRL_WIDTH-1:0] id_ctrl;

    logic                  of_valid;
    logic                  of_ready;
    logic [DATA_WIDTH-1:0] of_op1;
    logic [DATA_WIDTH-1:0] of_op2;
    logic [DATA_WIDTH-1:0] of_op3;
    logic [ADDR_WIDTH-1:0] of_rd;
    logic                  of_rd_we;
    logic                  of_is_load;
    logic [DATA_WIDTH-1:0] of_pc;
    logic [CTRL_WIDTH-1:0] of_ctrl;

    modport master (
        output id_valid, id_rn, id_rm, id_rs,
        output id_use_rn, id_use_rm, id_use_rs,
        output id_rd, id_rd_we, id_is_load, id_pc, id_ctrl,
        output of_ready,
        input  id_ready,
        input  of_valid, of_op1, of_op2, of_op3,
        input  of_rd, of_rd_we, of_is_load, of_pc, of_ctrl
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rs,
        input  id_use_rn, id_use_rm, id_use_rs,
        input  id_rd, id_rd_we, id_is_load, id_pc, id_ctrl,
        input  of_ready,
        output id_ready,
        output of_valid, of_op1, of_op2, of_op3,
        output of_rd, of_rd_we, of_is_load, of_pc, of_ctrl
    );
endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// Operand resolution for one source: PC read, EX forward, MEM forward or RF data.
// Ports: idx, rf_data, ex_* / mem_* forwarding inputs -> operand.
module of_fwd_mux
    import arm_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] operand
);
    fwd_src_e src;

    // PC reads come straight from the RF (it already adds 8);
    // an EX load has no data yet, so it never forwards.
    always_comb begin
        src = FWD_RF;
        if (idx == ADDR_WIDTH'(REG_PC))
            src = FWD_PC;
        else if (ex_valid && !ex_is_load && ex_addr == idx)
            src = FWD_EX;
        else if (mem_valid && mem_addr == idx)
            src = FWD_MEM;
    end

    always_comb begin
        operand = rf_data;
        unique case (src)
            FWD_EX:  operand = ex_data;
            FWD_MEM: operand = mem_data;
            FWD_PC:  operand = rf_data;
            FWD_RF:  operand = rf_data;
        endcase
    end
endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute stage: RF reads, forwarding, load-use stall, output slot.
// Ports: clk/rst/flush, bus (id/of channels), rf_*, ex_fwd_*, mem_fwd_*, stall_cnt.
module operand_fetch_stage
    import arm_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH = arm_core_pkg::CTRL_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    operand_fetch_stage_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    output logic [ADDR_WIDTH-1:0] rf_raddr3,
    output logic [DATA_WIDTH-1:0] rf_pc,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic [DATA_WIDTH-1:0] rf_rdata3,
    input  logic                  ex_fwd_valid,
    input  logic [ADDR_WIDTH-1:0] ex_fwd_addr,
    input  logic [DATA_WIDTH-1:0] ex_fwd_data,
    input  logic                  ex_fwd_is_load,
    input  logic                  mem_fwd_valid,
    input  logic [ADDR_WIDTH-1:0] mem_fwd_addr,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    logic [DATA_WIDTH-1:0] op1, op2, op3;
    logic hz_rn, hz_rm, hz_rs;
    logic load_use, slot_free, accept;

    assign rf_raddr1 = bus.id_rn;
    assign rf_raddr2 = bus.id_rm;
    assign rf_raddr3 = bus.id_rs;
    assign rf_pc     = bus.id_pc;

    of_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux_rn (
        .idx(bus.id_rn), .rf_data(rf_rdata1),
        .ex_valid(ex_fwd_valid), .ex_is_load(ex_fwd_is_load),
        .ex_addr(ex_fwd_addr), .ex_data(ex_fwd_data),
        .mem_valid(mem_fwd_valid), .mem_addr(mem_fwd_addr),
        .mem_data(mem_fwd_data), .operand(op1)
    );

    of_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux_rm (
        .idx(bus.id_rm), .rf_data(rf_rdata2),
        .ex_valid(ex_fwd_valid), .ex_is_load(ex_fwd_is_load),
        .ex_addr(ex_fwd_addr), .ex_data(ex_fwd_data),
        .mem_valid(mem_fwd_valid), .mem_addr(mem_fwd_addr),
        .mem_data(mem_fwd_data), .operand(op2)
    );

    of_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux_rs (
        .idx(bus.id_rs), .rf_data(rf_rdata3),
        .ex_valid(ex_fwd_valid), .ex_is_load(ex_fwd_is_load),
        .ex_addr(ex_fwd_addr), .ex_data(ex_fwd_data),
        .mem_valid(mem_fwd_valid), .mem_addr(mem_fwd_addr),
        .mem_data(mem_fwd_data), .operand(op3)
    );

    // R15 is supplied by the RF, so it can never wait on a load.
    assign hz_rn = bus.id_use_rn && bus.id_rn != ADDR_WIDTH'(REG_PC)
                   && bus.id_rn == ex_fwd_addr;
    assign hz_rm = bus.id_use_rm && bus.id_rm != ADDR_WIDTH'(REG_PC)
                   && bus.id_rm == ex_fwd_addr;
    assign hz_rs = bus.id_use_rs && bus.id_rs != ADDR_WIDTH'(REG_PC)
                   && bus.id_rs == ex_fwd_addr;

    assign load_use = bus.id_valid && ex_fwd_valid && ex_fwd_is_load
                      && (hz_rn || hz_rm || hz_rs);

    assign slot_free    = !bus.of_valid || bus.of_ready;
    assign bus.id_ready = slot_free && !load_use && !flush;
    assign accept       = bus.id_valid && bus.id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.of_valid   <= 1'b0;
            bus.of_op1     <= '0;
            bus.of_op2     <= '0;
            bus.of_op3     <= '0;
            bus.of_rd      <= '0;
            bus.of_rd_we   <= 1'b0;
            bus.of_is_load <= 1'b0;
            bus.of_pc      <= '0;
            bus.of_ctrl    <= '0;
        end else if (flush) begin
            bus.of_valid <= 1'b0;
        end else if (accept) begin
            bus.of_valid   <= 1'b1;
            bus.of_op1     <= op1;
            bus.of_op2     <= op2;
            bus.of_op3     <= op3;
            bus.of_rd      <= bus.id_rd;
            bus.of_rd_we   <= bus.id_rd_we;
            bus.of_is_load <= bus.id_is_load;
            bus.of_pc      <= bus.id_pc;
            bus.of_ctrl    <= bus.id_ctrl;
        end else if (slot_free) begin
            bus.of_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (load_use && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Testbench for operand_fetch_stage: directed scenarios then random traffic.
// Expected values come from a rule-level reference model of the stage.
module tb_operand_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_raddr3;
    logic [31:0] rf_pc;
    logic [31:0] rf_rdata1, rf_rdata2, rf_rdata3;
    logic        ex_v, ex_ld, mem_v;
    logic [3:0]  ex_a, mem_a;
    logic [31:0] ex_d, mem_d;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic        e_valid;
    logic [31:0] e_op1, e_op2, e_op3, e_pc;
    logic [3:0]  e_rd;
    logic        e_rd_we, e_is_load;
    logic [15:0] e_ctrl, e_cnt;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_raddr3(rf_raddr3), .rf_pc(rf_pc),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_rdata3(rf_rdata3),
        .ex_fwd_valid(ex_v), .ex_fwd_addr(ex_a),
        .ex_fwd_data(ex_d), .ex_fwd_is_load(ex_ld),
        .mem_fwd_valid(mem_v), .mem_fwd_addr(mem_a),
        .mem_fwd_data(mem_d), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_read(logic [3:0] a, logic [31:0] pc);
        return (a == 4'd15) ? pc + 32'd8 : 32'hA000_0000 + 32'(a);
    endfunction

    // register file environment
    always_comb begin
        rf_rdata1 = rf_read(rf_raddr1, rf_pc);
        rf_rdata2 = rf_read(rf_raddr2, rf_pc);
        rf_rdata3 = rf_read(rf_raddr3, rf_pc);
    end

    function automatic logic [31:0] exp_operand(logic [3:0] idx);
        if (idx == 4'd15) return bus.id_pc + 32'd8;
        if (ex_v && !ex_ld && ex_a == idx) return ex_d;
        if (mem_v && mem_a == idx) return mem_d;
        return 32'hA000_0000 + 32'(idx);
    endfunction

    function automatic logic waits(logic use_it, logic [3:0] idx);
        return use_it && idx != 4'd15 && idx == ex_a;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(string tag);
        chk({tag, ".of_valid"}, 32'(bus.of_valid), 32'(e_valid));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e_cnt));
        if (e_valid) begin
            chk({tag, ".op1"}, bus.of_op1, e_op1);
            chk({tag, ".op2"}, bus.of_op2, e_op2);
            chk({tag, ".op3"}, bus.of_op3, e_op3);
            chk({tag, ".rd"}, 32'(bus.of_rd), 32'(e_rd));
            chk({tag, ".rd_we"}, 32'(bus.of_rd_we), 32'(e_rd_we));
            chk({tag, ".is_load"}, 32'(bus.of_is_load), 32'(e_is_load));
            chk({tag, ".pc"}, bus.of_pc, e_pc);
            chk({tag, ".ctrl"}, 32'(bus.of_ctrl), 32'(e_ctrl));
        end
    endtask

    // One clock: check handshake, advance model, check registered outputs.
    task automatic step(string tag);
        logic lu, rdy, acc;
        #1;
        lu = bus.id_valid && ex_v && ex_ld
             && (waits(bus.id_use_rn, bus.id_rn)
                 || waits(bus.id_use_rm, bus.id_rm)
                 || waits(bus.id_use_rs, bus.id_rs));
        rdy = (!e_valid || bus.of_ready) && !lu && !flush;
        chk({tag, ".id_ready"}, 32'(bus.id_ready), 32'(rdy));
        acc = bus.id_valid && rdy;
        if (flush) begin
            e_valid = 1'b0;
        end else if (acc) begin
            e_valid   = 1'b1;
            e_op1     = exp_operand(bus.id_rn);
            e_op2     = exp_operand(bus.id_rm);
            e_op3     = exp_operand(bus.id_rs);
            e_rd      = bus.id_rd;
            e_rd_we   = bus.id_rd_we;
            e_is_load = bus.id_is_load;
            e_pc      = bus.id_pc;
            e_ctrl    = bus.id_ctrl;
        end else if (!e_valid || bus.of_ready) begin
            e_valid = 1'b0;
        end
        if (lu && !flush && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        @(posedge clk);
        #1;
        chk_outputs(tag);
    endtask

    task automatic issue(logic [3:0] rn, logic [3:0] rm, logic [3:0] rs,
                         logic [2:0] uses, logic [31:0] pc);
        bus.id_valid   = 1'b1;
        bus.id_rn      = rn;
        bus.id_rm      = rm;
        bus.id_rs      = rs;
        bus.id_use_rn  = uses[2];
        bus.id_use_rm  = uses[1];
        bus.id_use_rs  = uses[0];
        bus.id_rd      = rn ^ 4'd9;
        bus.id_rd_we   = pc[2];
        bus.id_is_load = pc[3];
        bus.id_pc      = pc;
        bus.id_ctrl    = pc[15:0] ^ 16'h5A5A;
    endtask

    task automatic no_fwd();
        ex_v = 0; ex_ld = 0; ex_a = 0; ex_d = 0;
        mem_v = 0; mem_a = 0; mem_d = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        e_valid = 1'b0;
        e_cnt   = 16'd0;
        chk("reset.of_valid", 32'(bus.of_valid), 32'd0);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        bus.of_ready = 1'b1;
        bus.id_valid = 1'b0;
        issue(0, 0, 0, 3'b000, 0);
        bus.id_valid = 1'b0;
        no_fwd();
        #2;
        do_reset();

        // reset state
        chk("reset.op1", bus.of_op1, 32'd0);
        chk("reset.op2", bus.of_op2, 32'd0);
        chk("reset.op3", bus.of_op3, 32'd0);
        chk("reset.pc", bus.of_pc, 32'd0);
        chk("reset.ctrl", 32'(bus.of_ctrl), 32'd0);
        chk("reset.id_ready", 32'(bus.id_ready), 32'd1);

        // 1: plain RF reads
        issue(3, 7, 14, 3'b111, 32'h100);
        chk("t1.raddr1", 32'(rf_raddr1), 32'd3);
        chk("t1.raddr3", 32'(rf_raddr3), 32'd14);
        step("t1");
        chk("t1.op1.const", bus.of_op1, 32'hA000_0003);
        chk("t1.op3.const", bus.of_op3, 32'hA000_000E);

        // 2: EX beats MEM, then MEM alone
        issue(5, 1, 2, 3'b111, 32'h104);
        ex_v = 1; ex_ld = 0; ex_a = 5; ex_d = 32'hDEAD_BEEF;
        mem_v = 1; mem_a = 5; mem_d = 32'h1234_5678;
        step("t2.ex");
        chk("t2.ex.const", bus.of_op1, 32'hDEAD_BEEF);
        ex_v = 0;
        step("t2.mem");
        chk("t2.mem.const", bus.of_op1, 32'h1234_5678);

        // 3: R15 reads PC+8, never forwarded nor stalled
        no_fwd();
        issue(15, 0, 0, 3'b100, 32'h2000);
        ex_v = 1; ex_ld = 1; ex_a = 15; ex_d = 32'h0BAD_0BAD;
        step("t3.load");
        chk("t3.const", bus.of_op1, 32'h0000_2008);
        ex_ld = 0;
        step("t3.alu");

        // 4: load-use on rm
        no_fwd();
        issue(1, 4, 2, 3'b111, 32'h300);
        ex_v = 1; ex_ld = 1; ex_a = 4; ex_d = 32'hCAFE_F00D;
        step("t4.s1");
        step("t4.s2");
        chk("t4.cnt.const", 32'(stall_cnt), 32'd2);
        ex_ld = 0;
        step("t4.go");
        chk("t4.op2.const", bus.of_op2, 32'hCAFE_F00D);
        ex_ld = 1;
        issue(1, 4, 2, 3'b101, 32'h304);
        step("t4.unused");

        // 5: backpressure then back-to-back
        no_fwd();
        bus.of_ready = 1'b0;
        issue(6, 8, 9, 3'b111, 32'h400);
        step("t5.load");
        issue(10, 11, 12, 3'b111, 32'h404);
        step("t5.h1");
        step("t5.h2");
        step("t5.h3");
        bus.of_ready = 1'b1;
        step("t5.b2b");
        issue(2, 3, 4, 3'b111, 32'h408);
        step("t5.next");

        // 6: flush with slot full and a pending instruction
        bus.of_ready = 1'b0;
        issue(7, 7, 7, 3'b111, 32'h500);
        flush = 1'b1;
        step("t6.flush");
        flush = 1'b0;
        bus.id_valid = 1'b0;
        step("t6.idle");

        // async reset mid-stream with a nonzero stall count
        bus.of_ready = 1'b1;
        issue(4, 0, 0, 3'b100, 32'h600);
        ex_v = 1; ex_ld = 1; ex_a = 4;
        step("t7.stall");
        issue(5, 0, 0, 3'b100, 32'h604);
        no_fwd();
        step("t7.fill");
        #2;
        do_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 3'($urandom),
                  $urandom & 32'hFFFF_FFFC);
            bus.id_valid   = ($urandom_range(0, 3) != 0);
            bus.id_ctrl    = 16'($urandom);
            bus.of_ready   = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            ex_v  = $urandom_range(0, 1) == 1;
            ex_ld = $urandom_range(0, 2) == 0;
            ex_a  = 4'($urandom_range(0, 15));
            ex_d  = $urandom;
            mem_v = $urandom_range(0, 1) == 1;
            mem_a = 4'($urandom_range(0, 15));
            mem_d = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
